// File: rtl/pkt_bufid_manager.sv
// -----------------------------------------------------------------------------
// pkt_bufid_manager
//
// Owns the free packet-buffer-ID pool of one switch port. After reset the pool
// is filled with ids 0..BUFID_NUM-1, one per cycle. Free ids are then offered
// to the network input process over a wr/ack handshake. Ids that come back
// through the release port are appended at the tail of the pool.
//
// Ports
//   clk_sys                     in   system clock
//   reset                       in   synchronous, active-high reset
//   o_pkt_bufid_wr              out  offered bufid is valid
//   ov_pkt_bufid                out  offered free bufid
//   i_pkt_bufid_ack             in   input process took the offered bufid
//   i_bufid_release_wr          in   return one bufid to the pool
//   iv_bufid_release            in   bufid being returned
//   ov_free_bufid_fifo_rdusedw  out  free bufids held, offered one included
//   o_init_done                 out  pool initialisation complete
//   o_release_drop_pulse        out  one-cycle pulse, a release was discarded
//   ov_bufid_mgr_state          out  FSM state (debug)
//
// Optional feature
//   BUFID_RELEASE_CHECK_EN : when defined, an allocated-id bitmap rejects
//   double releases, releases of never-allocated ids and out-of-range ids.
//
// States
//   state  | meaning
//   INIT_S | 2'b00, writing ids 0..BUFID_NUM-1 into the pool, releases dropped
//   RUN_S  | 2'b01, offering free ids and accepting releases
//   other  | unreachable, returns to INIT_S with the datapath cleared
// -----------------------------------------------------------------------------
module pkt_bufid_manager #(
    parameter int BUFID_W   = 9,
    parameter int BUFID_NUM = 256
) (
    input  logic               clk_sys,
    input  logic               reset,
    output logic               o_pkt_bufid_wr,
    output logic [BUFID_W-1:0] ov_pkt_bufid,
    input  logic               i_pkt_bufid_ack,
    input  logic               i_bufid_release_wr,
    input  logic [BUFID_W-1:0] iv_bufid_release,
    output logic [8:0]         ov_free_bufid_fifo_rdusedw,
    output logic               o_init_done,
    output logic               o_release_drop_pulse,
    output logic [1:0]         ov_bufid_mgr_state
);

    localparam int                 PTR_W    = (BUFID_NUM > 1) ? $clog2(BUFID_NUM) : 1;
    localparam logic [1:0]         INIT_S   = 2'b00;
    localparam logic [1:0]         RUN_S    = 2'b01;
    localparam logic [BUFID_W-1:0] LAST_ID  = BUFID_W'(BUFID_NUM - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(BUFID_NUM - 1);
    localparam logic [8:0]         CNT_FULL = 9'(BUFID_NUM);

    logic [1:0]         state_q;
    logic [1:0]         state_d;

    logic [BUFID_W-1:0] mem [0:BUFID_NUM-1];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [8:0]         cnt_q;          // stored ids plus the offered one
    logic [8:0]         stored;         // ids still inside the circular FIFO
    logic [BUFID_W-1:0] init_id_q;
    logic               out_valid_q;
    logic [BUFID_W-1:0] out_id_q;
    logic               drop_q;

    logic               in_init;
    logic               in_run;
    logic               init_last;
    logic               ack_take;
    logic               rel_legal;
    logic               rel_ok;
    logic               push;
    logic               pop;
    logic               drop_d;
    logic [BUFID_W-1:0] push_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= INIT_S;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = INIT_S;
        case (state_q)
            INIT_S:  state_d = init_last ? RUN_S : INIT_S;
            RUN_S:   state_d = RUN_S;
            default: state_d = INIT_S;
        endcase
    end

    always_comb begin
        o_init_done                = (state_q == RUN_S);
        ov_bufid_mgr_state         = state_q;
        o_pkt_bufid_wr             = out_valid_q;
        ov_pkt_bufid               = out_id_q;
        ov_free_bufid_fifo_rdusedw = cnt_q;
        o_release_drop_pulse       = drop_q;
    end

    // ------------------------------------------------------ release checker
`ifdef BUFID_RELEASE_CHECK_EN
    localparam logic [BUFID_W-1:0] ID_LIMIT = BUFID_W'(BUFID_NUM);

    logic [BUFID_NUM-1:0] alloc_q;
    logic [PTR_W-1:0]     rel_idx;
    logic [PTR_W-1:0]     ack_idx;

    always_comb begin
        rel_idx   = iv_bufid_release[PTR_W-1:0];
        ack_idx   = out_id_q[PTR_W-1:0];
        // Range test first so a truncated index never selects a foreign bit.
        rel_legal = (iv_bufid_release < ID_LIMIT) && alloc_q[rel_idx];
    end

    // An offered id is always free, so its bit is clear; a same-cycle release
    // of that id is therefore rejected rather than racing the set.
    always_ff @(posedge clk_sys) begin
        if (reset || !in_run) begin
            alloc_q <= '0;
        end else begin
            if (ack_take) alloc_q[ack_idx] <= 1'b1;
            if (rel_ok)   alloc_q[rel_idx] <= 1'b0;
        end
    end
`else
    always_comb begin
        rel_legal = 1'b1;
    end
`endif

    // ------------------------------------------------------------ datapath
    always_comb begin
        in_init   = (state_q == INIT_S);
        in_run    = (state_q == RUN_S);
        init_last = in_init && (init_id_q == LAST_ID);
        stored    = cnt_q - {8'd0, out_valid_q};
        ack_take  = in_run && out_valid_q && i_pkt_bufid_ack;
        rel_ok    = in_run && i_bufid_release_wr && (cnt_q != CNT_FULL) && rel_legal;
        drop_d    = i_bufid_release_wr && !rel_ok;
        push      = in_init || rel_ok;
        push_id   = in_init ? init_id_q : iv_bufid_release;
        // Refill the output stage whenever it is empty or being consumed;
        // a release lands in the FIFO first, hence the two-cycle refill.
        pop       = in_run && (!out_valid_q || ack_take) && (stored != 9'd0);
    end

    always_ff @(posedge clk_sys) begin
        if (reset || !(in_init || in_run)) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            init_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= drop_d;
            cnt_q  <= cnt_q + {8'd0, push} - {8'd0, ack_take};
            if (in_init) begin
                init_id_q <= init_id_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q    <= ptr_inc(rd_ptr_q);
                out_valid_q <= 1'b1;
                out_id_q    <= mem[rd_ptr_q];
            end else if (ack_take) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk_sys) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: tb/tb_pkt_bufid_manager.sv
module tb_pkt_bufid_manager;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       o_pkt_bufid_wr;
    logic [8:0] ov_pkt_bufid;
    logic       i_pkt_bufid_ack;
    logic       i_bufid_release_wr;
    logic [8:0] iv_bufid_release;
    logic [8:0] ov_free_bufid_fifo_rdusedw;
    logic       o_init_done;
    logic       o_release_drop_pulse;
    logic [1:0] ov_bufid_mgr_state;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_id;

    always #5 clk_sys = ~clk_sys;

    pkt_bufid_manager #(.BUFID_W(9), .BUFID_NUM(256)) dut (
        .clk_sys                    (clk_sys),
        .reset                      (reset),
        .o_pkt_bufid_wr             (o_pkt_bufid_wr),
        .ov_pkt_bufid               (ov_pkt_bufid),
        .i_pkt_bufid_ack            (i_pkt_bufid_ack),
        .i_bufid_release_wr         (i_bufid_release_wr),
        .iv_bufid_release           (iv_bufid_release),
        .ov_free_bufid_fifo_rdusedw (ov_free_bufid_fifo_rdusedw),
        .o_init_done                (o_init_done),
        .o_release_drop_pulse       (o_release_drop_pulse),
        .ov_bufid_mgr_state         (ov_bufid_mgr_state)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_pkt_bufid_ack = 1'b1; i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h1FF;
        tick();
        i_pkt_bufid_ack = 1'b0; i_bufid_release_wr = 1'b0; iv_bufid_release = '0;
        n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL reset_wr: got %0b want 0", o_pkt_bufid_wr); else n_pass++;
        n_checks++; if (ov_pkt_bufid !== 9'd0) $display("FAIL reset_id: got %0h want 0", ov_pkt_bufid); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd0) $display("FAIL reset_rdusedw: got %0d want 0", ov_free_bufid_fifo_rdusedw); else n_pass++;
        n_checks++; if (o_init_done !== 1'b0) $display("FAIL reset_init_done: got %0b want 0", o_init_done); else n_pass++;
        n_checks++; if (o_release_drop_pulse !== 1'b0) $display("FAIL reset_drop: got %0b want 0", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_bufid_mgr_state !== 2'b00) $display("FAIL reset_state: got %0d want 0", ov_bufid_mgr_state); else n_pass++;
        reset = 1'b0;
    endtask

    // Starts in cycle 0 (first cycle with reset low); ends in cycle 257.
    task automatic test_init();
        for (int i = 0; i < 256; i++) sb.push_back(9'(i));
        for (int k = 0; k < 256; k++) begin
            i_bufid_release_wr = (k == 5);
            iv_bufid_release   = 9'd7;
            tick();
            i_bufid_release_wr = 1'b0;
            n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'(k + 1)) $display("FAIL init_rdusedw c%0d: got %0d want %0d", k + 1, ov_free_bufid_fifo_rdusedw, k + 1); else n_pass++;
            n_checks++; if (o_release_drop_pulse !== (k == 5)) $display("FAIL init_drop c%0d: got %0b want %0b", k + 1, o_release_drop_pulse, (k == 5)); else n_pass++;
            n_checks++; if (o_init_done !== (k == 255)) $display("FAIL init_done c%0d: got %0b want %0b", k + 1, o_init_done, (k == 255)); else n_pass++;
            n_checks++; if (ov_bufid_mgr_state !== ((k == 255) ? 2'b01 : 2'b00)) $display("FAIL init_state c%0d: got %0d", k + 1, ov_bufid_mgr_state); else n_pass++;
            n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL init_wr c%0d: got %0b want 0", k + 1, o_pkt_bufid_wr); else n_pass++;
        end
        tick();
        exp_id = sb[0];
        n_checks++; if (o_pkt_bufid_wr !== 1'b1) $display("FAIL first_offer_wr: got %0b want 1", o_pkt_bufid_wr); else n_pass++;
        n_checks++; if (ov_pkt_bufid !== exp_id) $display("FAIL first_offer_id: got %0h want %0h", ov_pkt_bufid, exp_id); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd256) $display("FAIL first_offer_rdusedw: got %0d want 256", ov_free_bufid_fifo_rdusedw); else n_pass++;
    endtask

    task automatic test_overflow();
        i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h10;
        tick();
        i_bufid_release_wr = 1'b0;
        n_checks++; if (o_release_drop_pulse !== 1'b1) $display("FAIL ovf_drop: got %0b want 1", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd256) $display("FAIL ovf_rdusedw: got %0d want 256", ov_free_bufid_fifo_rdusedw); else n_pass++;
        tick();
        n_checks++; if (o_release_drop_pulse !== 1'b0) $display("FAIL ovf_drop_len: got %0b want 0", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd256) $display("FAIL ovf_rdusedw2: got %0d want 256", ov_free_bufid_fifo_rdusedw); else n_pass++;
        n_checks++; if (ov_pkt_bufid !== sb[0]) $display("FAIL ovf_stable_id: got %0h want %0h", ov_pkt_bufid, sb[0]); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 256; i++) begin
            n_checks++; if (o_pkt_bufid_wr !== 1'b1) $display("FAIL drain_wr i%0d: got %0b want 1", i, o_pkt_bufid_wr); else n_pass++;
            n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'(256 - i)) $display("FAIL drain_rdusedw i%0d: got %0d want %0d", i, ov_free_bufid_fifo_rdusedw, 256 - i); else n_pass++;
            n_checks++;
            if (sb.size() == 0) $display("FAIL drain_sb i%0d: got offer %0h want none", i, ov_pkt_bufid);
            else begin
                exp_id = sb.pop_front();
                if (ov_pkt_bufid !== exp_id) $display("FAIL drain_id i%0d: got %0h want %0h", i, ov_pkt_bufid, exp_id); else n_pass++;
            end
            i_pkt_bufid_ack = 1'b1;
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL empty_wr j%0d: got %0b want 0", j, o_pkt_bufid_wr); else n_pass++;
            n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd0) $display("FAIL empty_rdusedw j%0d: got %0d want 0", j, ov_free_bufid_fifo_rdusedw); else n_pass++;
            tick();
        end
        i_pkt_bufid_ack = 1'b0;
    endtask

    task automatic test_empty_refill();
        i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h2A;
        sb.push_back(9'h2A);
        tick();
        i_bufid_release_wr = 1'b0;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd1) $display("FAIL refill_rdusedw: got %0d want 1", ov_free_bufid_fifo_rdusedw); else n_pass++;
        n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL refill_wr_early: got %0b want 0", o_pkt_bufid_wr); else n_pass++;
        n_checks++; if (o_release_drop_pulse !== 1'b0) $display("FAIL refill_drop: got %0b want 0", o_release_drop_pulse); else n_pass++;
        tick();
        n_checks++; if (o_pkt_bufid_wr !== 1'b1) $display("FAIL refill_wr: got %0b want 1", o_pkt_bufid_wr); else n_pass++;
        n_checks++; if (ov_pkt_bufid !== 9'h2A) $display("FAIL refill_id: got %0h want 2a", ov_pkt_bufid); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [8:0] last_id;
        last_id = '0;
        for (int j = 0; j < 9; j++) begin
            i_bufid_release_wr = 1'b1; iv_bufid_release = 9'(9'h30 + j);
            sb.push_back(9'(9'h30 + j));
            tick();
        end
        i_bufid_release_wr = 1'b0;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd10) $display("FAIL simul_pre_rdusedw: got %0d want 10", ov_free_bufid_fifo_rdusedw); else n_pass++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL simul_sb: got offer %0h want none", ov_pkt_bufid);
        else begin
            exp_id = sb.pop_front();
            if (ov_pkt_bufid !== exp_id) $display("FAIL simul_ack_id: got %0h want %0h", ov_pkt_bufid, exp_id); else n_pass++;
        end
        i_pkt_bufid_ack = 1'b1; i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h05;
        sb.push_back(9'h05);
        tick();
        i_pkt_bufid_ack = 1'b0; i_bufid_release_wr = 1'b0;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd10) $display("FAIL simul_rdusedw: got %0d want 10", ov_free_bufid_fifo_rdusedw); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (o_pkt_bufid_wr !== 1'b1) $display("FAIL simul_drain_wr i%0d: got %0b want 1", i, o_pkt_bufid_wr); else n_pass++;
            n_checks++;
            if (sb.size() == 0) $display("FAIL simul_drain_sb i%0d: got offer %0h want none", i, ov_pkt_bufid);
            else begin
                exp_id = sb.pop_front();
                if (ov_pkt_bufid !== exp_id) $display("FAIL simul_drain_id i%0d: got %0h want %0h", i, ov_pkt_bufid, exp_id); else n_pass++;
            end
            last_id = ov_pkt_bufid;
            i_pkt_bufid_ack = 1'b1;
            tick();
        end
        i_pkt_bufid_ack = 1'b0;
        n_checks++; if (last_id !== 9'h05) $display("FAIL simul_last_id: got %0h want 05", last_id); else n_pass++;
        n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL simul_end_wr: got %0b want 0", o_pkt_bufid_wr); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd0) $display("FAIL simul_end_rdusedw: got %0d want 0", ov_free_bufid_fifo_rdusedw); else n_pass++;
    endtask

    task automatic test_release_check();
        int n;
        i_bufid_release_wr = 1'b1; iv_bufid_release = 9'd3;
        sb.push_back(9'd3);
        tick();
        n_checks++; if (o_release_drop_pulse !== 1'b0) $display("FAIL dbl_first_drop: got %0b want 0", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd1) $display("FAIL dbl_first_rdusedw: got %0d want 1", ov_free_bufid_fifo_rdusedw); else n_pass++;
        tick();
        i_bufid_release_wr = 1'b0;
`ifdef BUFID_RELEASE_CHECK_EN
        n_checks++; if (o_release_drop_pulse !== 1'b1) $display("FAIL dbl_second_drop: got %0b want 1", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd1) $display("FAIL dbl_second_rdusedw: got %0d want 1", ov_free_bufid_fifo_rdusedw); else n_pass++;
`else
        sb.push_back(9'd3);
        n_checks++; if (o_release_drop_pulse !== 1'b0) $display("FAIL dbl_second_drop: got %0b want 0", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd2) $display("FAIL dbl_second_rdusedw: got %0d want 2", ov_free_bufid_fifo_rdusedw); else n_pass++;
`endif
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            n_checks++; if (o_pkt_bufid_wr !== 1'b1) $display("FAIL dbl_drain_wr i%0d: got %0b want 1", i, o_pkt_bufid_wr); else n_pass++;
            exp_id = sb.pop_front();
            n_checks++; if (ov_pkt_bufid !== exp_id) $display("FAIL dbl_drain_id i%0d: got %0h want %0h", i, ov_pkt_bufid, exp_id); else n_pass++;
            i_pkt_bufid_ack = 1'b1;
            tick();
        end
        i_pkt_bufid_ack = 1'b0;
        n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL dbl_end_wr: got %0b want 0", o_pkt_bufid_wr); else n_pass++;
`ifdef BUFID_RELEASE_CHECK_EN
        i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h1FF;
        tick();
        i_bufid_release_wr = 1'b0;
        n_checks++; if (o_release_drop_pulse !== 1'b1) $display("FAIL range_drop: got %0b want 1", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd0) $display("FAIL range_rdusedw: got %0d want 0", ov_free_bufid_fifo_rdusedw); else n_pass++;
`endif
    endtask

    task automatic test_mid_reset();
        i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h11;
        tick();
        i_bufid_release_wr = 1'b0;
        reset = 1'b1; i_pkt_bufid_ack = 1'b1;
        tick();
        reset = 1'b0; i_pkt_bufid_ack = 1'b0;
        n_checks++; if (ov_bufid_mgr_state !== 2'b00) $display("FAIL mid_rst_state: got %0d want 0", ov_bufid_mgr_state); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd0) $display("FAIL mid_rst_rdusedw: got %0d want 0", ov_free_bufid_fifo_rdusedw); else n_pass++;
        n_checks++; if (o_pkt_bufid_wr !== 1'b0) $display("FAIL mid_rst_wr: got %0b want 0", o_pkt_bufid_wr); else n_pass++;
        n_checks++; if (o_init_done !== 1'b0) $display("FAIL mid_rst_init_done: got %0b want 0", o_init_done); else n_pass++;
        sb.delete();
        test_init();
        for (int i = 0; i < 2; i++) begin
            exp_id = sb.pop_front();
            n_checks++; if (ov_pkt_bufid !== exp_id) $display("FAIL rebuild_id i%0d: got %0h want %0h", i, ov_pkt_bufid, exp_id); else n_pass++;
            i_pkt_bufid_ack = 1'b1;
            tick();
        end
        i_pkt_bufid_ack = 1'b0;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd254) $display("FAIL rebuild_rdusedw: got %0d want 254", ov_free_bufid_fifo_rdusedw); else n_pass++;
        i_bufid_release_wr = 1'b1; iv_bufid_release = 9'h40;
        tick();
        i_bufid_release_wr = 1'b0;
`ifdef BUFID_RELEASE_CHECK_EN
        n_checks++; if (o_release_drop_pulse !== 1'b1) $display("FAIL unalloc_drop: got %0b want 1", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd254) $display("FAIL unalloc_rdusedw: got %0d want 254", ov_free_bufid_fifo_rdusedw); else n_pass++;
`else
        sb.push_back(9'h40);
        n_checks++; if (o_release_drop_pulse !== 1'b0) $display("FAIL blind_drop: got %0b want 0", o_release_drop_pulse); else n_pass++;
        n_checks++; if (ov_free_bufid_fifo_rdusedw !== 9'd255) $display("FAIL blind_rdusedw: got %0d want 255", ov_free_bufid_fifo_rdusedw); else n_pass++;
`endif
    endtask

    initial begin
        reset = 1'b1;
        i_pkt_bufid_ack = 1'b0;
        i_bufid_release_wr = 1'b0;
        iv_bufid_release = '0;
        test_reset();
        test_init();
        test_overflow();
        test_drain();
        test_empty_refill();
        test_simultaneous();
        test_release_check();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
